// File: rtl/y_bcd_converter.sv
// y_bcd_converter: sequential double-dabble binary-to-BCD converter with go/busy/done handshake.
// Define Y_SIGNED_EN to treat Y as two's complement and add the neg output.
module y_bcd_converter #(
  parameter int IN_W   = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  go,
  input  logic [IN_W-1:0]       Y,
  output logic                  busy,
  output logic                  done,
`ifdef Y_SIGNED_EN
  output logic                  neg,
`endif
  output logic [4*DIGITS-1:0]   bcd
);
  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(IN_W + 1);
  function automatic longint unsigned pow10(input int n);
    longint unsigned p = 1;
    for (int i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction
  if (pow10(DIGITS) <= (64'd1 << IN_W) - 64'd1) begin : g_bad_digits
    $error("y_bcd_converter: DIGITS too small for IN_W");
  end
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t          state_q, state_d;
  logic            go_q;
  logic [IN_W-1:0] bin_q, bin_d, bin_sh, bin_ld;
  logic [BW-1:0]   scr_q, scr_d, scr_sh, adj;
  logic [BW-1:0]   bcd_q, bcd_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            busy_q, busy_d, done_q, done_d;
  logic            trig;
  assign trig = go & ~go_q;
`ifdef Y_SIGNED_EN
  logic            sgn_q, sgn_d, neg_q, neg_d;
  logic [IN_W:0]   mag;
  // one extra bit so the most negative input has an exact magnitude
  assign mag    = Y[IN_W-1] ? (IN_W+1)'(0) - {Y[IN_W-1], Y} : {1'b0, Y};
  assign bin_ld = mag[IN_W-1:0];
  assign neg    = neg_q;
`else
  assign bin_ld = Y;
`endif
  always_comb begin
    adj = scr_q;
    for (int i = 0; i < DIGITS; i++)
      adj[4*i +: 4] = (scr_q[4*i +: 4] >= 4'd5) ? scr_q[4*i +: 4] + 4'd3 : scr_q[4*i +: 4];
    {scr_sh, bin_sh} = {adj, bin_q} << 1;
  end
  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    scr_d   = scr_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    bcd_d   = bcd_q;
`ifdef Y_SIGNED_EN
    sgn_d   = sgn_q;
    neg_d   = neg_q;
`endif
    if (state_q == IDLE) begin
      if (trig) begin
        bin_d   = bin_ld;
        scr_d   = '0;
        cnt_d   = '0;
        busy_d  = 1'b1;
        state_d = SHIFT;
`ifdef Y_SIGNED_EN
        sgn_d   = Y[IN_W-1];
`endif
      end
    end else begin
      bin_d = bin_sh;
      scr_d = scr_sh;
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == CW'(IN_W - 1)) begin
        bcd_d   = scr_sh;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
`ifdef Y_SIGNED_EN
        neg_d   = sgn_q;
`endif
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      go_q    <= 1'b0;
      bin_q   <= '0;
      scr_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      bcd_q   <= '0;
`ifdef Y_SIGNED_EN
      sgn_q   <= 1'b0;
      neg_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      go_q    <= go;
      bin_q   <= bin_d;
      scr_q   <= scr_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      bcd_q   <= bcd_d;
`ifdef Y_SIGNED_EN
      sgn_q   <= sgn_d;
      neg_q   <= neg_d;
`endif
    end
  end
  assign busy = busy_q;
  assign done = done_q;
  assign bcd  = bcd_q;
endmodule

// File: tb/tb_y_bcd_converter.sv
// tb_y_bcd_converter: directed checks of handshake timing, edge detect, reset abort and BCD results.
module tb_y_bcd_converter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        go = 1'b0;
  logic [7:0]  Y = 8'd0;
  logic        busy, done;
  logic [11:0] bcd;
`ifdef Y_SIGNED_EN
  logic        neg;
`endif
  int total = 0;
  int fails = 0;
  y_bcd_converter #(.IN_W(8), .DIGITS(3)) dut (
    .clk(clk), .rst(rst), .go(go), .Y(Y), .busy(busy), .done(done),
`ifdef Y_SIGNED_EN
    .neg(neg),
`endif
    .bcd(bcd)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic wait_done(output int bc, output bit seen);
    bc = 0;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (done) begin
        seen = 1;
        break;
      end
      if (busy) bc++;
      tick();
    end
  endtask
  task automatic conv(input logic [7:0] y, input logic [11:0] exp, input string tag);
    int bc;
    bit seen;
    Y = y;
    go = 1'b1;
    tick();
    go = 1'b0;
    wait_done(bc, seen);
    chk({tag, "_busy_cycles"}, bc, 8);
    chk({tag, "_done"}, {31'd0, seen}, 1);
    chk({tag, "_bcd"}, {20'd0, bcd}, {20'd0, exp});
  endtask
  initial begin
    int bc, dcnt;
    bit seen;
    tick();
    tick();
    rst = 1'b0;
    chk("reset_busy", {31'd0, busy}, 0);
    chk("reset_done", {31'd0, done}, 0);
    chk("reset_bcd", {20'd0, bcd}, 0);
    // go held high for the whole conversion: one done, no retrigger
    Y = 8'd3;
    go = 1'b1;
    tick();
    chk("y3_busy_first", {31'd0, busy}, 1);
    wait_done(bc, seen);
    chk("y3_busy_cycles", bc, 8);
    chk("y3_done", {31'd0, seen}, 1);
    chk("y3_bcd", {20'd0, bcd}, 12'h003);
    tick();
    chk("y3_done_pulse", {31'd0, done}, 0);
    chk("y3_no_retrigger", {31'd0, busy}, 0);
    go = 1'b0;
    tick();
`ifdef Y_SIGNED_EN
    conv(8'd255, 12'h001, "y255");
    chk("y255_neg", {31'd0, neg}, 1);
`else
    conv(8'd255, 12'h255, "y255");
`endif
    tick();
    conv(8'd0, 12'h000, "y0");
    tick();
    // retrigger attempt and input change while busy
    Y = 8'd99;
    go = 1'b1;
    tick();
    go = 1'b0;
    tick();
    go = 1'b1;
    Y = 8'd7;
    tick();
    go = 1'b0;
    wait_done(bc, seen);
    chk("y99_busy_rest", bc, 6);
    chk("y99_done", {31'd0, seen}, 1);
    chk("y99_bcd", {20'd0, bcd}, 12'h099);
    dcnt = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done) dcnt++;
    end
    chk("y99_single_done", dcnt, 0);
    chk("y99_bcd_hold", {20'd0, bcd}, 12'h099);
    conv(8'd7, 12'h007, "y7");
    tick();
    // back-to-back: trigger in the done cycle
    Y = 8'd128;
    go = 1'b1;
    tick();
    go = 1'b0;
    wait_done(bc, seen);
    chk("y128_done", {31'd0, seen}, 1);
    chk("y128_bcd", {20'd0, bcd}, 12'h128);
    Y = 8'd42;
    go = 1'b1;
    tick();
    go = 1'b0;
    chk("b2b_accept", {31'd0, busy}, 1);
    wait_done(bc, seen);
    chk("b2b_period", bc + 1, 9);
    chk("b2b_done", {31'd0, seen}, 1);
    chk("y42_bcd", {20'd0, bcd}, 12'h042);
    tick();
    // reset on the 4th busy cycle aborts the conversion
    Y = 8'd200;
    go = 1'b1;
    tick();
    go = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_busy", {31'd0, busy}, 0);
    chk("abort_bcd", {20'd0, bcd}, 0);
    dcnt = 0;
    for (int i = 0; i < 12; i++) begin
      if (done) dcnt++;
      tick();
    end
    chk("abort_no_done", dcnt, 0);
    chk("abort_bcd_hold", {20'd0, bcd}, 0);
    conv(8'd17, 12'h017, "y17");
`ifdef Y_SIGNED_EN
    tick();
    conv(8'hF3, 12'h013, "yF3");
    chk("yF3_neg", {31'd0, neg}, 1);
    tick();
    conv(8'h80, 12'h128, "y80");
    chk("y80_neg", {31'd0, neg}, 1);
    tick();
    conv(8'h7F, 12'h127, "y7F");
    chk("y7F_neg", {31'd0, neg}, 0);
`endif
    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule
